sram_seq_ctrl: RTL and testbench

Digital timing controller for the mixed-signal SRAM macro: write driver, cell array and sense amp. It accepts single-word read/write requests over a valid/ready handshake and sequences precharge, write/read wordlines, write-driver enable and sense-amp enable with programmable cycle counts. It captures sense-amp output into a registered read-data port. Generalises the hand-driven single-row wordline stimulus to ROWS rows with enforced phase ordering and wordline exclusivity.

---
 rtl/sram_seq_ctrl_if.sv | 31 +++
 rtl/sram_seq_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_sram_seq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_seq_ctrl_if.sv
// Request-side handshake bundle between a requester and sram_seq_ctrl.
// The requester drives a single-word read/write request and holds it
// until req_ready is seen high at a rising clock edge.
interface sram_seq_ctrl_if #(
    parameter int ROWS = 2,
    parameter int COLS = 8
);
    localparam int AW = $clog2(ROWS);

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [COLS-1:0] req_wdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready
    );
endinterface

// File: rtl/sram_seq_ctrl.sv
// Timing sequencer for the mixed-signal SRAM macro (write driver, cell array,
// sense amp). One request at a time is taken from the handshake and walked
// through precharge, wordline and sense phases of programmable length.
// Every macro-facing output is a flop, decoded from the next state, so there
// is no combinational path from any input to any output.
module sram_seq_ctrl #(
    parameter int ROWS    = 2,
    parameter int COLS    = 8,
    parameter int T_PRE   = 2,
    parameter int T_WL_WR = 4,
    parameter int T_WL_RD = 3,
    parameter int T_SA    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_seq_ctrl_if.slave       req,
    output logic [ROWS-1:0]      row_wr,
    output logic [ROWS-1:0]      row_rd,
    output logic                 wd_en,
    output logic [COLS-1:0]      wd_data,
    output logic                 pre_en,
    output logic                 sa_en,
    input  logic [COLS-1:0]      sa_dout,
    output logic [COLS-1:0]      rdata,
    output logic                 rvalid,
    output logic                 err
);

    localparam int AW = $clog2(ROWS);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Phase counter only has to hold the longest phase length minus one.
    localparam int T_MAX = max_of(max_of(T_PRE, T_WL_WR), max_of(T_WL_RD, T_SA));
    localparam int CNT_W = $clog2(T_MAX) + 1;

    localparam logic [CNT_W-1:0] LD_PRE   = CNT_W'(T_PRE - 1);
    localparam logic [CNT_W-1:0] LD_WL_WR = CNT_W'(T_WL_WR - 1);
    localparam logic [CNT_W-1:0] LD_WL_RD = CNT_W'(T_WL_RD - 1);
    localparam logic [CNT_W-1:0] LD_SA    = CNT_W'(T_SA - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // One extra bit so the row count itself is representable even when
    // ROWS is an exact power of two.
    localparam logic [AW:0] ROWS_L = (AW + 1)'(ROWS);

    // Decode a row index into a one-hot wordline vector.
    function automatic logic [ROWS-1:0] row_select(input logic [AW-1:0] a);
        return ROWS'(1) << a;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        PRECH,
        WRITE,
        READ_WL,
        SENSE,
        RECOVER
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Latched request fields (wd_data doubles as the latched write word).
    logic             we_q;
    logic [AW-1:0]    addr_q;

    logic             ready_q;
    logic             take;
    logic             addr_bad;
    logic             capture;

    // Next values of the registered macro-facing outputs.
    logic [ROWS-1:0]  row_wr_nxt;
    logic [ROWS-1:0]  row_rd_nxt;
    logic             wd_en_nxt;
    logic             pre_en_nxt;
    logic             sa_en_nxt;
    logic             rvalid_nxt;
    logic             err_nxt;
    logic             ready_nxt;

    assign req.req_ready = ready_q;
    assign addr_bad      = ({1'b0, req.req_addr} >= ROWS_L);

    // Next-state, phase-counter reload and output decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        take       = 1'b0;
        capture    = 1'b0;
        if (cnt != '0) begin
            cnt_nxt = cnt - CNT_ONE;
        end

        case (state)
            IDLE: begin
                if (req.req_valid && ready_q) begin
                    take = 1'b1;
                    if (addr_bad) begin
                        state_nxt = RECOVER;
                    end else begin
                        state_nxt = PRECH;
                        cnt_nxt   = LD_PRE;
                    end
                end
            end
            PRECH: begin
                if (cnt == '0) begin
                    if (we_q) begin
                        state_nxt = WRITE;
                        cnt_nxt   = LD_WL_WR;
                    end else begin
                        state_nxt = READ_WL;
                        cnt_nxt   = LD_WL_RD;
                    end
                end
            end
            WRITE: begin
                if (cnt == '0) begin
                    state_nxt = RECOVER;
                end
            end
            READ_WL: begin
                if (cnt == '0) begin
                    state_nxt = SENSE;
                    cnt_nxt   = LD_SA;
                end
            end
            SENSE: begin
                if (cnt == '0) begin
                    state_nxt = RECOVER;
                    capture   = 1'b1;
                end
            end
            RECOVER: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Outputs follow the state being entered, so they line up with it
        // once registered. Wordlines never appear on the handshake edge, so
        // the already-latched address is always the right one to decode.
        pre_en_nxt = (state_nxt == PRECH);
        wd_en_nxt  = (state_nxt == WRITE);
        sa_en_nxt  = (state_nxt == SENSE);
        row_wr_nxt = (state_nxt == WRITE) ? row_select(addr_q) : '0;
        row_rd_nxt = (state_nxt == READ_WL || state_nxt == SENSE) ? row_select(addr_q) : '0;
        rvalid_nxt = capture;
        err_nxt    = take && addr_bad;
        ready_nxt  = (state_nxt == IDLE);
    end

    // State register and phase counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered macro-facing controls; reset drops every enable at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_wr  <= '0;
            row_rd  <= '0;
            wd_en   <= 1'b0;
            pre_en  <= 1'b0;
            sa_en   <= 1'b0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            row_wr  <= row_wr_nxt;
            row_rd  <= row_rd_nxt;
            wd_en   <= wd_en_nxt;
            pre_en  <= pre_en_nxt;
            sa_en   <= sa_en_nxt;
            rvalid  <= rvalid_nxt;
            err     <= err_nxt;
            ready_q <= ready_nxt;
        end
    end

    // Request latch on handshake and read-word capture at the end of sensing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_data <= '0;
            rdata   <= '0;
        end else begin
            if (take) begin
                we_q    <= req.req_we;
                addr_q  <= req.req_addr;
                wd_data <= req.req_wdata;
            end
            if (capture) begin
                rdata <= sa_dout;
            end
        end
    end

    // Electrical safety rules for the macro.
    a_wl_excl: assert property (@(posedge clk) disable iff (!rst_n)
        $countones(row_wr | row_rd) <= 1);
    a_pre_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(pre_en && (|(row_wr | row_rd))));
    a_wd_with_wl: assert property (@(posedge clk) disable iff (!rst_n)
        !wd_en || (|row_wr));
    a_sa_with_wl: assert property (@(posedge clk) disable iff (!rst_n)
        !sa_en || (|row_rd));

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Bench for sram_seq_ctrl: directed and random requests, a behavioural
// cell-array model answering the sense amp, a per-cycle output trace queue
// and a response queue, both filled when a request is accepted.
module tb_sram_seq_ctrl;
    localparam int ROWS    = 3;
    localparam int COLS    = 8;
    localparam int T_PRE   = 2;
    localparam int T_WL_WR = 4;
    localparam int T_WL_RD = 3;
    localparam int T_SA    = 2;
    localparam int AW      = $clog2(ROWS);
    localparam int LAT_WR  = T_PRE + T_WL_WR + 1;
    localparam int LAT_RD  = T_PRE + T_WL_RD + T_SA + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_seq_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus();

    logic [ROWS-1:0] row_wr;
    logic [ROWS-1:0] row_rd;
    logic            wd_en;
    logic [COLS-1:0] wd_data;
    logic            pre_en;
    logic            sa_en;
    logic [COLS-1:0] sa_dout;
    logic [COLS-1:0] rdata;
    logic            rvalid;
    logic            err;

    sram_seq_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .T_PRE(T_PRE),
        .T_WL_WR(T_WL_WR), .T_WL_RD(T_WL_RD), .T_SA(T_SA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(bus),
        .row_wr(row_wr), .row_rd(row_rd), .wd_en(wd_en), .wd_data(wd_data),
        .pre_en(pre_en), .sa_en(sa_en), .sa_dout(sa_dout),
        .rdata(rdata), .rvalid(rvalid), .err(err)
    );

    typedef struct packed {
        logic            ready;
        logic            pre;
        logic [ROWS-1:0] wr;
        logic [ROWS-1:0] rd;
        logic            wd;
        logic            sa;
        logic            rv;
        logic            er;
        logic [COLS-1:0] wdd;
        logic [COLS-1:0] rdd;
    } obs_t;

    typedef struct packed {
        logic            is_err;
        logic [COLS-1:0] data;
    } resp_t;

    obs_t  trace_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [COLS-1:0] ref_mem [ROWS];
    logic [COLS-1:0] mac_mem [ROWS];
    logic [COLS-1:0] noise;
    logic [COLS-1:0] last_rdata;
    obs_t            mon_e;
    resp_t           mon_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.ready = bus.req_ready;
        o.pre   = pre_en;
        o.wr    = row_wr;
        o.rd    = row_rd;
        o.wd    = wd_en;
        o.sa    = sa_en;
        o.rv    = rvalid;
        o.er    = err;
        o.wdd   = wd_data;
        o.rdd   = rdata;
        return o;
    endfunction

    // Cell array: written by the write driver, read back through the sense amp.
    always @(posedge clk) begin
        noise <= COLS'($urandom);
        if (wd_en) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_wr[r]) mac_mem[r] <= wd_data;
            end
        end
    end

    always_comb begin
        sa_dout = noise;
        if (sa_en) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_rd[r]) sa_dout = mac_mem[r];
            end
        end
    end

    // Monitor: per-cycle trace and response scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (trace_q.size() > 0) begin
                mon_e = trace_q.pop_front();
                check("trace", 64'(observe()), 64'(mon_e));
            end
            if (rvalid || err) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 64'({rvalid, err}), 64'(0));
                end else begin
                    mon_r = resp_q.pop_front();
                    check("resp_kind", 64'({rvalid, err}), 64'({!mon_r.is_err, mon_r.is_err}));
                    if (!mon_r.is_err) check("resp_rdata", 64'(rdata), 64'(mon_r.data));
                end
            end
        end
    end

    // Safety invariants on the macro controls, every cycle.
    always @(negedge clk) begin
        check("invariants", 64'(($countones(row_wr | row_rd) <= 1) &&
                                !(pre_en && (|(row_wr | row_rd))) &&
                                (!wd_en || (|row_wr)) &&
                                (!sa_en || (|row_rd))), 64'(1));
    end

    // Present one request, record what the controller must do, keep noise on
    // the bus while busy. Called and returns at a falling edge.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [COLS-1:0] wd);
        int              n;
        int              lat;
        logic            bad;
        logic [ROWS-1:0] oh;
        logic [COLS-1:0] nxt_rd;
        obs_t            o;
        resp_t           r;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("handshake_timeout", 64'(0), 64'(1));
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        bad    = (int'(addr) >= ROWS);
        oh     = '0;
        nxt_rd = last_rdata;
        if (!bad) begin
            oh[int'(addr)] = 1'b1;
            if (!we) nxt_rd = ref_mem[int'(addr)];
        end
        lat = bad ? 1 : (we ? LAT_WR : LAT_RD);
        for (int k = 1; k <= lat + 1; k++) begin
            o     = '0;
            o.wdd = wd;
            o.rdd = (k >= lat) ? nxt_rd : last_rdata;
            if (k == lat + 1)         o.ready = 1'b1;
            else if (bad)             o.er    = 1'b1;
            else if (k <= T_PRE)      o.pre   = 1'b1;
            else if (k == lat)        o.rv    = !we;
            else if (we) begin
                o.wr = oh;
                o.wd = 1'b1;
            end else begin
                o.rd = oh;
                o.sa = (k > T_PRE + T_WL_RD);
            end
            trace_q.push_back(o);
        end
        if (bad) begin
            r.is_err = 1'b1;
            r.data   = '0;
            resp_q.push_back(r);
        end else if (we) begin
            ref_mem[int'(addr)] = wd;
        end else begin
            r.is_err = 1'b0;
            r.data   = nxt_rd;
            resp_q.push_back(r);
            last_rdata = nxt_rd;
        end
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_we    = 1'($urandom_range(0, 1));
            bus.req_addr  = AW'($urandom_range(0, 3));
            bus.req_wdata = COLS'($urandom);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((trace_q.size() != 0 || resp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(trace_q.size() + resp_q.size()), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t exp_o;
        for (int r = 0; r < ROWS; r++) ref_mem[r] = '0;
        last_rdata    = '0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = '0;
        bus.req_wdata = 8'hFF;

        // Reset held with a request pending: everything quiet, no handshake.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_outputs", 64'(observe()), 64'(0));
        end
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        exp_o       = '0;
        exp_o.ready = 1'b1;
        check("ready_after_reset", 64'(observe()), 64'(exp_o));

        // Directed: write, read back, row isolation, other rows, bad address.
        issue(1'b1, AW'(0), 8'hB7);
        issue(1'b0, AW'(0), 8'h00);
        issue(1'b1, AW'(1), 8'h00);
        issue(1'b0, AW'(0), 8'h00);
        issue(1'b1, AW'(2), 8'h5C);
        issue(1'b0, AW'(1), 8'h00);
        issue(1'b0, AW'(2), 8'h00);
        issue(1'b1, AW'(3), 8'hA5);
        issue(1'b0, AW'(3), 8'h00);

        // Random traffic with idle gaps.
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), COLS'($urandom));
        end
        drain();

        // Reset during the first sense cycle of a read.
        issue(1'b1, AW'(0), 8'hB7);
        issue(1'b0, AW'(0), 8'h00);
        drain();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = AW'(0);
        bus.req_wdata = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (T_PRE + T_WL_RD) @(negedge clk);
        check("sense_reached", 64'({sa_en, row_rd}), 64'({1'b1, ROWS'(1)}));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_midop", 64'(observe()), 64'(0));
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", 64'(observe()), 64'(0));
        end
        rst_n      = 1'b1;
        last_rdata = '0;
        @(negedge clk);
        check("ready_after_midop_reset", 64'(observe()), 64'(exp_o));
        issue(1'b1, AW'(1), 8'h3C);
        issue(1'b0, AW'(1), 8'h00);
        issue(1'b0, AW'(0), 8'h00);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
